// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART parity encodings, receiver FSM states and oversampling constants
package uart_pkg;

    localparam logic [1:0] PARITY_NONE = 2'b00;
    localparam logic [1:0] PARITY_ODD  = 2'b01;
    localparam logic [1:0] PARITY_EVEN = 2'b10;

    localparam int OVERSAMPLE = 16;
    localparam int TICK_W     = $clog2(OVERSAMPLE);
    localparam logic [TICK_W-1:0] SAMPLE_IDX = TICK_W'(8);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_t;

    function automatic logic parity_enabled(input logic [1:0] ptype);
        return (ptype == PARITY_ODD) || (ptype == PARITY_EVEN);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - rx synchroniser, start-edge detect, 16x tick counter and bit decision
// UART_RX_MAJORITY_VOTE_EN selects a 2-of-3 vote over tick indices 6/7/8 instead of a single tick-7 sample.
module uart_rx_sampler
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic tick_16x,
    input  logic rx,
    input  logic restart,
    output logic fall_edge,
    output logic bit_strobe,
    output logic bit_value
);

    localparam logic [TICK_W-1:0] IDX_LATE = SAMPLE_IDX - TICK_W'(1);

    logic              rx_meta;
    logic              rx_sync;
    logic              rx_prev;
    logic [TICK_W-1:0] tick_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // A held-low line cannot retrigger: prev must have seen a 1 first.
    assign fall_edge = rx_prev & ~rx_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt <= '0;
        end else if (restart) begin
            tick_cnt <= '0;
        end else if (tick_16x) begin
            tick_cnt <= tick_cnt + TICK_W'(1);
        end
    end

    assign bit_strobe = tick_16x && (tick_cnt == SAMPLE_IDX);

`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam logic [TICK_W-1:0] IDX_EARLY = SAMPLE_IDX - TICK_W'(2);

    logic early;
    logic late;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            early <= 1'b1;
            late  <= 1'b1;
        end else if (tick_16x) begin
            if (tick_cnt == IDX_EARLY) early <= rx_sync;
            if (tick_cnt == IDX_LATE)  late  <= rx_sync;
        end
    end

    // Third vote is the live sample at the decision tick itself.
    assign bit_value = (early & late) | (early & rx_sync) | (late & rx_sync);
`else
    logic mid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mid <= 1'b1;
        end else if (tick_16x && (tick_cnt == IDX_LATE)) begin
            mid <= rx_sync;
        end
    end

    assign bit_value = mid;
`endif

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver top: frame FSM, shift register, parity/stop checks, output registers
// Bit decision style is chosen in uart_rx_sampler by UART_RX_MAJORITY_VOTE_EN.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick_16x,
    input  logic                  rx,
    input  logic [1:0]            parity_type,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  parity_error,
    output logic                  stop_error,
    output logic                  busy
);

    localparam int BIT_W = $clog2(DATA_WIDTH);

    rx_state_t             state;
    rx_state_t             state_nxt;
    logic                  fall_edge;
    logic                  bit_strobe;
    logic                  bit_value;
    logic                  restart;
    logic [DATA_WIDTH-1:0] shreg;
    logic [BIT_W-1:0]      bit_cnt;
    logic [1:0]            frame_ptype;
    logic                  par_flag;
    logic                  last_bit;
    logic                  par_expected;

    assign restart  = (state == ST_IDLE) && fall_edge;
    assign last_bit = (bit_cnt == BIT_W'(DATA_WIDTH - 1));
    assign par_expected = (frame_ptype == PARITY_EVEN) ? ^shreg : ~^shreg;

    uart_rx_sampler u_sampler (
        .clk        (clk),
        .rst        (rst),
        .tick_16x   (tick_16x),
        .rx         (rx),
        .restart    (restart),
        .fall_edge  (fall_edge),
        .bit_strobe (bit_strobe),
        .bit_value  (bit_value)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (fall_edge)  state_nxt = ST_START;
            ST_START:  if (bit_strobe) state_nxt = bit_value ? ST_IDLE : ST_DATA;
            ST_DATA:   if (bit_strobe && last_bit)
                           state_nxt = parity_enabled(frame_ptype) ? ST_PARITY : ST_STOP;
            ST_PARITY: if (bit_strobe) state_nxt = ST_STOP;
            ST_STOP:   if (bit_strobe) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out     <= '0;
            data_valid   <= 1'b0;
            parity_error <= 1'b0;
            stop_error   <= 1'b0;
            busy         <= 1'b0;
            shreg        <= '0;
            bit_cnt      <= '0;
            frame_ptype  <= PARITY_NONE;
            par_flag     <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (bit_strobe) begin
                case (state)
                    ST_START: if (!bit_value) begin
                        // parity_type is frozen here so mid-frame changes are ignored
                        frame_ptype <= parity_type;
                        bit_cnt     <= '0;
                        par_flag    <= 1'b0;
                        busy        <= 1'b1;
                    end
                    ST_DATA: begin
                        shreg   <= {bit_value, shreg[DATA_WIDTH-1:1]};
                        bit_cnt <= bit_cnt + BIT_W'(1);
                    end
                    ST_PARITY: par_flag <= (bit_value != par_expected);
                    ST_STOP: begin
                        data_out     <= shreg;
                        parity_error <= par_flag;
                        stop_error   <= ~bit_value;
                        data_valid   <= 1'b1;
                        busy         <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx against a frame-level reference model
module tb_uart_rx;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          tick_16x = 1'b0;
    logic          rx = 1'b1;
    logic [1:0]    parity_type = 2'b00;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          parity_error;
    logic          stop_error;
    logic          busy;

    uart_rx #(.DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .tick_16x     (tick_16x),
        .rx           (rx),
        .parity_type  (parity_type),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .parity_error (parity_error),
        .stop_error   (stop_error),
        .busy         (busy)
    );

    int checks = 0;
    int errors = 0;
    int tick_period = 4;
    int tdiv = 0;
    int tick_count = 0;
    int start_tick = 0;
    int dv_count = 0;
    int dv_wide = 0;
    int exp_total = 0;
    logic prev_dv = 1'b0;

    int exp_data[$], exp_perr[$], exp_serr[$], exp_lat[$];
    int obs_data[$], obs_perr[$], obs_serr[$], obs_lat[$];

    always #5 clk = ~clk;

    initial forever begin
        @(negedge clk);
        tick_16x = (tdiv == 0);
        tdiv = (tdiv + 1 >= tick_period) ? 0 : tdiv + 1;
    end

    initial forever begin
        @(posedge clk);
        if (tick_16x === 1'b1) tick_count++;
    end

    initial forever begin
        @(negedge clk);
        if (data_valid === 1'b1) begin
            obs_data.push_back(int'(data_out));
            obs_perr.push_back(parity_error ? 1 : 0);
            obs_serr.push_back(stop_error ? 1 : 0);
            obs_lat.push_back(tick_count - start_tick);
            dv_count++;
            if (prev_dv === 1'b1) dv_wide++;
        end
        prev_dv = data_valid;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not complete (checks=%0d errors=%0d)", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Parity error from the count of ones over data plus parity bit.
    function automatic int model_perr(input logic [DW-1:0] d, input logic [1:0] pt, input logic pb);
        int ones;
        ones = $countones(d) + (pb ? 1 : 0);
        if (pt == 2'b01) return (ones % 2 == 0) ? 1 : 0;
        if (pt == 2'b10) return (ones % 2 == 1) ? 1 : 0;
        return 0;
    endfunction

    task automatic push_exp(input int d, input int pe, input int se, input int lat);
        exp_data.push_back(d);
        exp_perr.push_back(pe);
        exp_serr.push_back(se);
        exp_lat.push_back(lat);
        exp_total++;
    endtask

    task automatic wait_tick();
        @(posedge clk);
        while (tick_16x !== 1'b1) @(posedge clk);
    endtask

    task automatic wait_ticks(input int n);
        for (int k = 0; k < n; k++) wait_tick();
    endtask

    // Must be called right after a tick edge; bit boundaries stay tick-aligned.
    task automatic send_frame(input logic [1:0] pt, input logic [DW-1:0] d, input logic pb,
                              input logic sb, input int gap, input int glitch, input bit scramble);
        logic [15:0] f;
        int n;
        bit hp;
        hp = (pt == 2'b01) || (pt == 2'b10);
        f = '0;
        for (int i = 0; i < DW; i++) f[1+i] = d[i];
        n = 1 + DW;
        if (hp) begin
            f[n] = pb;
            n++;
        end
        f[n] = sb;
        n++;
        push_exp(int'(d), model_perr(d, pt, pb), sb ? 0 : 1,
                 (tick_period == 4) ? (n - 1) * 16 + 9 : -1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx = f[i];
            if (i == 0) begin
                parity_type = pt;
                start_tick  = tick_count;
            end
            if (i == 3 && scramble) parity_type = 2'($urandom);
            if (i == 5) check("busy_mid_frame", busy, 1'b1);
            if (i == glitch) begin
                wait_ticks(7);
                @(negedge clk);
                rx = 1'b0;
                wait_ticks(1);
                @(negedge clk);
                rx = 1'b1;
                wait_ticks(8);
            end else begin
                wait_ticks(16);
            end
        end
        if (gap > 0) begin
            @(negedge clk);
            rx = 1'b1;
            check("busy_after_frame", busy, 1'b0);
            wait_ticks(gap);
        end
    endtask

    task automatic check_frames(input string tag);
        int guard;
        int e;
        int o;
        guard = 0;
        while (obs_data.size() < exp_data.size() && guard < 4000) begin
            @(negedge clk);
            guard++;
        end
        check({tag, "_count"}, obs_data.size(), exp_data.size());
        while (exp_data.size() > 0 && obs_data.size() > 0) begin
            e = exp_data.pop_front(); o = obs_data.pop_front();
            check({tag, "_data"}, o, e);
            e = exp_perr.pop_front(); o = obs_perr.pop_front();
            check({tag, "_parity_error"}, o, e);
            e = exp_serr.pop_front(); o = obs_serr.pop_front();
            check({tag, "_stop_error"}, o, e);
            e = exp_lat.pop_front(); o = obs_lat.pop_front();
            if (e >= 0) check({tag, "_latency"}, o, e);
        end
        exp_data.delete(); exp_perr.delete(); exp_serr.delete(); exp_lat.delete();
        obs_data.delete(); obs_perr.delete(); obs_serr.delete(); obs_lat.delete();
    endtask

    initial begin
        logic [DW-1:0] d;
        logic [DW-1:0] ld;
        logic pb;
        logic sb;
        int gap;
        int n0;

        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_data_out", data_out, '0);
        check("reset_data_valid", data_valid, 1'b0);
        check("reset_parity_error", parity_error, 1'b0);
        check("reset_stop_error", stop_error, 1'b0);
        check("reset_busy", busy, 1'b0);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_no_valid", dv_count, 0);

        wait_tick();
        send_frame(2'b10, 8'hA5, 1'b0, 1'b1, 32, -1, 1'b0);
        check_frames("8e1");

        send_frame(2'b01, 8'h0F, 1'b0, 1'b1, 32, -1, 1'b0);
        check_frames("odd_error");

        send_frame(2'b00, 8'h3C, 1'b0, 1'b1, 32, -1, 1'b0);
        check_frames("8n1_00");
        send_frame(2'b11, 8'h3C, 1'b0, 1'b1, 32, -1, 1'b0);
        check_frames("8n1_11");

        for (int r = 0; r < 16; r++) begin
            d   = DW'($urandom);
            pb  = 1'($urandom);
            sb  = ($urandom_range(0, 5) != 0);
            gap = sb ? $urandom_range(0, 20) : $urandom_range(2, 20);
            send_frame(2'($urandom), d, pb, sb, gap, -1, 1'b1);
            check_frames("random");
        end

        // Break: line low far beyond one frame yields a single all-zero frame.
        wait_tick();
        @(negedge clk);
        rx = 1'b0;
        parity_type = 2'b00;
        start_tick = tick_count;
        push_exp(0, 0, 1, 153);
        wait_ticks(12 * 16);
        check_frames("break");
        n0 = dv_count;
        @(negedge clk);
        rx = 1'b1;
        wait_ticks(48);
        check("break_single_valid", dv_count, n0);

        // False start: 4-tick low pulse.
        n0 = dv_count;
        @(negedge clk);
        rx = 1'b0;
        wait_ticks(4);
        @(negedge clk);
        rx = 1'b1;
        wait_ticks(6);
        @(negedge clk);
        check("false_start_busy", busy, 1'b0);
        wait_ticks(40);
        check("false_start_no_valid", dv_count, n0);
        send_frame(2'b00, 8'hC3, 1'b0, 1'b1, 16, -1, 1'b0);
        check_frames("after_false_start");

`ifdef UART_RX_MAJORITY_VOTE_EN
        send_frame(2'b00, 8'hFF, 1'b0, 1'b1, 16, 4, 1'b0);
        check_frames("glitch_reject");
`endif

        // tick_16x every clock: data_valid must still be a single cycle.
        @(negedge clk);
        tick_period = 1;
        wait_ticks(4);
        send_frame(2'b10, 8'h81, 1'b0, 1'b1, 0, -1, 1'b0);
        send_frame(2'b01, 8'h7E, 1'b0, 1'b1, 32, -1, 1'b0);
        check_frames("fast_tick");
        check("fast_tick_pulse_width", dv_wide, 0);
        @(negedge clk);
        tick_period = 4;
        wait_ticks(4);

        // Reset during data bit 5 aborts the frame.
        n0 = dv_count;
        ld = 8'h33;
        @(negedge clk);
        rx = 1'b0;
        parity_type = 2'b10;
        wait_ticks(16);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rx = ld[i];
            wait_ticks(16);
        end
        @(negedge clk);
        rx = ld[5];
        wait_ticks(8);
        @(negedge clk);
        check("abort_busy_before", busy, 1'b1);
        rst = 1'b0;
        #1;
        check("abort_data_out", data_out, '0);
        check("abort_busy", busy, 1'b0);
        check("abort_data_valid", data_valid, 1'b0);
        check("abort_stop_error", stop_error, 1'b0);
        repeat (3) @(negedge clk);
        rx = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        wait_ticks(48);
        check("abort_no_valid", dv_count, n0);
        check_frames("abort");

        send_frame(2'b10, 8'h55, 1'b0, 1'b1, 0, -1, 1'b0);
        send_frame(2'b01, 8'hE7, 1'b1, 1'b1, 32, -1, 1'b0);
        check_frames("back_to_back");

        check("valid_pulse_width", dv_wide, 0);
        check("total_frames", dv_count, exp_total);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
